// File: rtl/sdram_scheduler.sv
//==============================================================================
// sdram_scheduler : N-way arbiter onto one SDRAM bank port, read-ack watchdog.
// Macro SDRAM_SCHEDULER_FIXED_PRIORITY_EN selects fixed priority. Rev 1.0
//==============================================================================
`default_nettype none

`ifndef BANK_ROM
`define BANK_ROM 4'd1
`endif

module sdram_scheduler #(
  parameter int         NUM_CONTROLLERS = 3,
  parameter int         ADDRESS_WIDTH   = 25,
  parameter logic [3:0] DEVICE_BANK     = `BANK_ROM,
  parameter int         TIMEOUT_CYCLES  = 1024
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset_n,
  input  logic [NUM_CONTROLLERS-1:0]           i_request,
  input  logic [NUM_CONTROLLERS-1:0]           i_write,
  input  logic [4*NUM_CONTROLLERS-1:0]         i_bank,
  input  logic [ADDRESS_WIDTH*NUM_CONTROLLERS-1:0] i_address,
  input  logic [32*NUM_CONTROLLERS-1:0]        i_data,
  output logic [NUM_CONTROLLERS-1:0]           o_busy,
  output logic [NUM_CONTROLLERS-1:0]           o_ack,
  output logic [32*NUM_CONTROLLERS-1:0]        o_data,
  output logic                                 o_device_request,
  output logic                                 o_device_write,
  input  logic                                 i_device_busy,
  input  logic                                 i_device_ack,
  output logic [ADDRESS_WIDTH-1:0]             o_device_address,
  output logic [31:0]                          o_device_data,
  input  logic [31:0]                          i_device_data,
  output logic                                 o_timeout
);

  localparam int c_idx_w = (NUM_CONTROLLERS > 1) ? $clog2(NUM_CONTROLLERS) : 1;
  localparam int c_wd_w  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_wd_w-1:0]  c_wd_last = c_wd_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_CONTROLLERS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                          r_state;
  state_t                          w_next_state;
  logic [NUM_CONTROLLERS-1:0]      w_eligible;
  logic [NUM_CONTROLLERS-1:0]      w_grant_mask;
  logic                            w_found;
  logic [c_idx_w-1:0]              w_winner;
  logic                            w_wd_expired;
  // r_owner doubles as last_grant for the round-robin search
  logic [c_idx_w-1:0]              r_owner;
  logic                            r_write;
  logic [ADDRESS_WIDTH-1:0]        r_address;
  logic [31:0]                     r_wdata;
  logic [31:0]                     r_rdata;
  logic [c_wd_w-1:0]               r_watchdog;
  logic [NUM_CONTROLLERS-1:0]      r_ack;
  logic [32*NUM_CONTROLLERS-1:0]   r_data;
  logic                            r_timeout;

  for (genvar k = 0; k < NUM_CONTROLLERS; k++) begin : g_eligible
    assign w_eligible[k] = i_request[k] && (i_bank[4*k +: 4] == DEVICE_BANK);
  end

`ifdef SDRAM_SCHEDULER_FIXED_PRIORITY_EN
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = NUM_CONTROLLERS - 1; k >= 0; k--) begin
      if (w_eligible[k]) begin
        w_found  = 1'b1;
        w_winner = c_idx_w'(k);
      end
    end
  end
`else
  always_comb begin
    int w_idx;
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int i = 0; i < NUM_CONTROLLERS; i++) begin
      w_idx = int'(r_owner) + i + 1;
      if (w_idx >= NUM_CONTROLLERS) w_idx = w_idx - NUM_CONTROLLERS;
      if (!w_found && w_eligible[w_idx]) begin
        w_found  = 1'b1;
        w_winner = c_idx_w'(w_idx);
      end
    end
  end
`endif

  always_comb begin
    w_grant_mask = '0;
    if (r_state == IDLE && w_found) w_grant_mask[w_winner] = 1'b1;
  end

  assign o_busy       = w_eligible & ~w_grant_mask;
  assign w_wd_expired = (r_watchdog == c_wd_last);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_found) w_next_state = ISSUE;
      ISSUE:   if (!i_device_busy) w_next_state = r_write ? IDLE : WAIT;
      WAIT:    if (i_device_ack || w_wd_expired) w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= IDLE;
      r_owner    <= c_last_idx;
      r_write    <= 1'b0;
      r_address  <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_watchdog <= '0;
      r_ack      <= '0;
      r_data     <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_ack   <= '0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_owner   <= w_winner;
            r_write   <= i_write[w_winner];
            r_address <= i_address[ADDRESS_WIDTH*w_winner +: ADDRESS_WIDTH];
            r_wdata   <= i_data[32*w_winner +: 32];
          end
        end
        ISSUE: r_watchdog <= '0;
        WAIT: begin
          // a real ack beats a watchdog expiry landing in the same cycle
          if (i_device_ack) begin
            r_rdata <= i_device_data;
          end else if (w_wd_expired) begin
            r_rdata   <= 32'hFFFF_FFFF;
            r_timeout <= 1'b1;
          end else begin
            r_watchdog <= r_watchdog + 1'b1;
          end
        end
        RESP: begin
          for (int k = 0; k < NUM_CONTROLLERS; k++) begin
            if (k == int'(r_owner)) begin
              r_ack[k]         <= 1'b1;
              r_data[32*k +: 32] <= r_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_device_request = (r_state == ISSUE);
  assign o_device_write   = (r_state == ISSUE) && r_write;
  assign o_device_address = r_address;
  assign o_device_data    = r_wdata;
  assign o_ack            = r_ack;
  assign o_data           = r_data;
  assign o_timeout        = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_sdram_scheduler.sv
//==============================================================================
// tb_sdram_scheduler : directed self-checking bench for sdram_scheduler.
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_sdram_scheduler;

  localparam logic [24:0] c_a0 = 25'h000010;
  localparam logic [24:0] c_a1 = 25'h000020;
  localparam logic [24:0] c_a2 = 25'h000030;
`ifdef SDRAM_SCHEDULER_FIXED_PRIORITY_EN
  localparam logic [7:0] c_seq01 = 8'h00;
  localparam logic [7:0] c_seq02 = 8'h00;
  localparam bit         c_fixed = 1'b1;
`else
  localparam logic [7:0] c_seq01 = 8'h44;  // 0,1,0,1
  localparam logic [7:0] c_seq02 = 8'h88;  // 0,2,0,2
  localparam bit         c_fixed = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic [2:0]  i_request, i_write;
  logic [11:0] i_bank;
  logic [74:0] i_address;
  logic [95:0] i_data;
  wire  [2:0]  o_busy, o_ack;
  wire  [95:0] o_data;
  wire         o_device_request, o_device_write, o_timeout;
  logic        i_device_busy;
  wire         i_device_ack;
  wire  [24:0] o_device_address;
  wire  [31:0] o_device_data;
  logic [31:0] i_device_data;

  logic        model_ack = 1'b0;
  logic        man_ack   = 1'b0;
  logic        dev_en    = 1'b0;
  int          dev_delay = 2;
  int          cd        = 0;
  logic [24:0] addr_lat  = '0;

  int checks   = 0;
  int failures = 0;

  assign i_device_ack = model_ack | man_ack;

  sdram_scheduler dut (
    .i_clk            (i_clk),
    .i_reset_n        (i_reset_n),
    .i_request        (i_request),
    .i_write          (i_write),
    .i_bank           (i_bank),
    .i_address        (i_address),
    .i_data           (i_data),
    .o_busy           (o_busy),
    .o_ack            (o_ack),
    .o_data           (o_data),
    .o_device_request (o_device_request),
    .o_device_write   (o_device_write),
    .i_device_busy    (i_device_busy),
    .i_device_ack     (i_device_ack),
    .o_device_address (o_device_address),
    .o_device_data    (o_device_data),
    .i_device_data    (i_device_data),
    .o_timeout        (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] exp_rd(input logic [24:0] a);
    return 32'hA5A5_0000 ^ {7'b0, a};
  endfunction

  function automatic logic [24:0] addr_of(input int k);
    return (k == 0) ? c_a0 : (k == 1) ? c_a1 : c_a2;
  endfunction

  // Device model: read data is a function of the accepted address, ack after dev_delay cycles
  always @(posedge i_clk) begin
    #2;
    model_ack = 1'b0;
    if (cd > 0) begin
      cd = cd - 1;
      if (cd == 0) begin
        model_ack     = 1'b1;
        i_device_data = exp_rd(addr_lat);
      end
    end
    if (dev_en && o_device_request && !o_device_write && !i_device_busy) begin
      cd       = dev_delay;
      addr_lat = o_device_address;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_reads(input logic [2:0] mask, input logic [7:0] exp_seq, input string name);
    int   n;
    int   idx;
    logic prev;
    n    = 0;
    prev = 1'b0;
    dev_en    = 1'b1;
    dev_delay = 2;
    i_write   = 3'b000;
    i_request = mask;
    for (int c = 0; c < 200 && n < 4; c++) begin
      @(negedge i_clk);
      if (prev) check({name, "_pulse"}, {61'b0, o_ack}, 64'd0);
      prev = 1'b0;
      if (o_ack != 3'b000) begin
        idx = int'(exp_seq[2*n +: 2]);
        check({name, "_grant"}, {61'b0, o_ack}, 64'(3'b001 << idx));
        check({name, "_data"}, {32'b0, o_data[32*idx +: 32]}, {32'b0, exp_rd(addr_of(idx))});
        n++;
        prev = 1'b1;
        if (n == 4) i_request = 3'b000;
      end
    end
    check({name, "_count"}, 64'(n), 64'd4);
    @(negedge i_clk);
    check({name, "_pulse"}, {61'b0, o_ack}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

  initial begin
    int req_cycles;
    int c;
    logic any_ack, any_req;

    i_reset_n     = 1'b0;
    i_request     = '0;
    i_write       = '0;
    i_bank        = {4'd1, 4'd1, 4'd1};
    i_address     = {c_a2, c_a1, c_a0};
    i_data        = '0;
    i_device_busy = 1'b0;
    i_device_data = '0;
    repeat (3) @(negedge i_clk);
    check("rst_busy", {61'b0, o_busy}, 64'd0);
    check("rst_ack", {61'b0, o_ack}, 64'd0);
    check("rst_data", o_data[63:0], 64'd0);
    check("rst_devreq", {62'b0, o_device_request, o_device_write}, 64'd0);
    check("rst_timeout", {63'b0, o_timeout}, 64'd0);
    i_reset_n = 1'b1;
    @(negedge i_clk);

    // Round-robin between requesters 0 and 1
    i_request = 3'b011;
    #1;
    check("busy_arb", {61'b0, o_busy}, 64'b010);
    run_reads(3'b011, c_seq01, "rr01");
    check("lane0_hold", {32'b0, o_data[31:0]}, {32'b0, exp_rd(c_a0)});
    check("lane1_hold", {32'b0, o_data[63:32]}, c_fixed ? 64'd0 : {32'b0, exp_rd(c_a1)});

    // Write held off by device busy
    i_device_busy       = 1'b1;
    i_write             = 3'b010;
    i_address[49:25]    = 25'h000100;
    i_data[63:32]       = 32'hDEAD_BEEF;
    i_request           = 3'b010;
    req_cycles = 0;
    any_ack    = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge i_clk);
      if (k == 0) i_request = 3'b000;
      if (o_ack != 3'b000) any_ack = 1'b1;
      if (o_device_request) begin
        req_cycles++;
        check("wr_fields", {6'b0, o_device_write, o_device_address, o_device_data},
              {6'b0, 1'b1, 25'h000100, 32'hDEAD_BEEF});
        i_device_busy = (req_cycles < 6);
      end
    end
    i_device_busy = 1'b0;
    check("wr_hold", 64'(req_cycles), 64'd6);
    check("wr_noack", {63'b0, any_ack}, 64'd0);
    check("wr_idle", {63'b0, o_device_request}, 64'd0);
    i_write          = 3'b000;
    i_address[49:25] = c_a1;

    // Wrong-bank requester stays invisible
    i_bank[11:8] = 4'd0;
    i_request    = 3'b100;
    any_req      = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      if (o_device_request) any_req = 1'b1;
      check("bank_busy", {61'b0, o_busy}, 64'd0);
    end
    check("bank_noreq", {63'b0, any_req}, 64'd0);
    i_request    = 3'b000;
    i_bank[11:8] = 4'd1;

    // Stray device ack while idle
    man_ack = 1'b1;
    @(negedge i_clk);
    man_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      check("stray_ack", {61'b0, o_ack}, 64'd0);
    end

    // Watchdog timeout
    dev_en    = 1'b0;
    i_request = 3'b001;
    for (c = 1; c <= 1100; c++) begin
      @(negedge i_clk);
      if (c == 1) i_request = 3'b000;
      if (o_ack != 3'b000) break;
    end
    check("to_latency", 64'(c), 64'd1027);
    check("to_ack", {61'b0, o_ack}, 64'b001);
    check("to_data", {32'b0, o_data[31:0]}, 64'hFFFF_FFFF);
    check("to_flag", {63'b0, o_timeout}, 64'd1);

    // Zero-wait read latency; timeout flag stays sticky
    dev_en    = 1'b1;
    dev_delay = 1;
    i_request = 3'b001;
    for (c = 1; c <= 20; c++) begin
      @(negedge i_clk);
      if (c == 1) i_request = 3'b000;
      if (o_ack != 3'b000) break;
    end
    check("lat_cycles", 64'(c), 64'd4);
    check("lat_data", {32'b0, o_data[31:0]}, {32'b0, exp_rd(c_a0)});
    check("to_sticky", {63'b0, o_timeout}, 64'd1);

    // Reset during WAIT, then a late ack
    @(negedge i_clk);
    dev_en    = 1'b0;
    i_request = 3'b001;
    for (int k = 1; k <= 3; k++) begin
      @(negedge i_clk);
      if (k == 1) i_request = 3'b000;
    end
    i_reset_n = 1'b0;
    #1;
    check("arst_outs", {o_device_request, o_device_write, o_timeout, o_ack, o_device_address, o_device_data},
          64'd0);
    check("arst_data", o_data[63:0], 64'd0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    man_ack   = 1'b1;
    @(negedge i_clk);
    man_ack = 1'b0;
    any_ack = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge i_clk);
      if (o_ack != 3'b000) any_ack = 1'b1;
    end
    check("arst_noack", {63'b0, any_ack}, 64'd0);
    check("arst_idle", {o_device_request, o_timeout, o_ack, o_data[58:0]}, 64'd0);

    // Requesters 0 and 2 contending
    run_reads(3'b101, c_seq02, "pri02");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sdram_scheduler.md
SDRAM_SCHEDULER -- requirements
Module: sdram_scheduler

Interface
REQ-001 Parameter NUM_CONTROLLERS, default 3, is the number of requesters; index 0 is N64, index 1 is PC, index 2 is debug DMA.
REQ-002 Parameter ADDRESS_WIDTH, default 25, is the device word-address width.
REQ-003 Parameter DEVICE_BANK, default BANK_ROM from constants.vh, is the bank this scheduler serves.
REQ-004 Parameter TIMEOUT_CYCLES, default 1024, is the read-ack watchdog limit.
REQ-005 i_clk, input, 1: single clock; all logic SHALL run on its rising edge.
REQ-006 i_reset_n, input, 1: reset, asynchronous, active-low.
REQ-007 i_request / i_write, input, N each: per-requester request and write flag.
REQ-008 i_bank, input, 4N: per-requester bank. i_address, input, ADDRESS_WIDTH*N. i_data, input, 32N: write data.
REQ-009 o_busy / o_ack, output, N each: per-requester stall and read-complete pulse. o_data, output, 32N: read data.
REQ-010 o_device_request / o_device_write, output, 1 each. i_device_busy / i_device_ack, input, 1 each.
REQ-011 o_device_address, output, ADDRESS_WIDTH. o_device_data, output, 32. i_device_data, input, 32.
REQ-012 o_timeout, output, 1: sticky watchdog flag.

Function
REQ-013 Requester k is eligible when i_request[k]=1 and i_bank[k] equals DEVICE_BANK.
REQ-014 States SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-015 In IDLE, the winner SHALL be the first eligible index searched from last_grant+1, wrapping modulo N.
REQ-016 o_busy[k] SHALL be combinational: eligible[k] AND NOT (state==IDLE AND winner==k). Non-eligible requesters SHALL never see busy.
REQ-017 Acceptance occurs in the IDLE cycle with an eligible winner. On acceptance, the scheduler SHALL latch the winner's write flag, address and data, set last_grant to the winner, and go to ISSUE.
REQ-018 In ISSUE, o_device_request=1 with the latched fields. The device accepts in a cycle with o_device_request=1 and i_device_busy=0. After acceptance, a write SHALL go to IDLE and a read SHALL go to WAIT.
REQ-019 In WAIT, when i_device_ack=1, the scheduler SHALL capture i_device_data and go to RESP.
REQ-020 In RESP, o_ack[winner] SHALL pulse for exactly 1 cycle with o_data[winner] valid, then return to IDLE. Minimum read latency is 4 cycles from acceptance to o_ack given a zero-wait device.
REQ-021 Writes SHALL produce no o_ack.
REQ-022 If WAIT lasts TIMEOUT_CYCLES cycles, the scheduler SHALL go to RESP with data 32'hFFFF_FFFF and set o_timeout.
REQ-023 If i_device_ack arrives in the same cycle as the timeout, the ack wins and o_timeout is not set.
REQ-024 i_device_ack outside WAIT SHALL be ignored.
REQ-025 o_data lanes of non-acked requesters SHALL hold their last values.
REQ-026 o_timeout SHALL clear only on reset.

Reset
REQ-027 On i_reset_n=0, asynchronously: state=IDLE, last_grant=N-1, watchdog=0, o_device_request=0, o_device_write=0, o_ack=0, o_data=0, o_device_address=0, o_device_data=0, o_timeout=0.
REQ-028 Reset asserted mid-transaction SHALL abort the transaction; no o_ack SHALL be issued afterwards for it.

Configuration
REQ-029 With SDRAM_SCHEDULER_FIXED_PRIORITY_EN defined, the winner SHALL be the lowest eligible index and last_grant SHALL be unused.
REQ-030 Without SDRAM_SCHEDULER_FIXED_PRIORITY_EN, round-robin per REQ-015 SHALL apply.

Verification
REQ-031 Requesters 0 and 1 both read bank DEVICE_BANK continuously; device acks after 2 cycles -> grants alternate 0,1,0,1; each o_ack is 1 cycle with the correct data (macro undefined).
REQ-032 Requester 1 writes address 0x000100 with data 0xDEADBEEF while i_device_busy=1 for 5 cycles -> o_device_request is held 6 cycles with stable fields; no o_ack; return to IDLE.
REQ-033 Requester 2 requests bank != DEVICE_BANK -> o_busy[2]=0 and no device request.
REQ-034 Read with no device ack -> o_ack after 1024 WAIT cycles with data 0xFFFFFFFF and o_timeout=1.
REQ-035 i_reset_n pulsed low during WAIT, then a late i_device_ack -> no o_ack and all outputs at reset values.
REQ-036 Macro defined, requesters 0 and 2 requesting continuously -> requester 0 always granted.
